// File: rtl/fifo_async_pop_buf.sv
// Ring buffer with head-of-queue output, enqueue/dequeue strobes and a synchronous clear.
// Storage is not reset; pointers and count are cleared by async rst or by clr_i.
module fifo_async_pop_buf #(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   enq_i,
  input  logic [W-1:0]           enq_data_i,
  input  logic                   deq_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(D+1)-1:0] count_o
);
  localparam int PTR_W = $clog2(D);
  localparam int CNT_W = $clog2(D+1);

  logic [W-1:0]     mem_q [D];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq_i, deq_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage carries no reset so it can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (enq_i && !clr_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fifo_async_pop_ctrl.sv
// Read-side pop sequencer: issues credit-checked pops, absorbs the 1-cycle pop latency in a
// prefetch buffer and drives a valid/ready stream; 2-cycle empty-to-valid, flush, sticky err.
module fifo_async_pop_ctrl #(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty_r,
  output logic                   fifo_pop,
  input  logic [W-1:0]           fifo_pop_data,
  input  logic                   fifo_pop_data_vld_r,
  input  logic                   flush,
  output logic                   out_vld,
  output logic [W-1:0]           out_data,
  input  logic                   out_rdy,
  output logic [$clog2(D+1)-1:0] level_r,
  output logic                   err_r
);
  localparam int CNT_W = $clog2(D+1);
  localparam logic [CNT_W:0] DEPTH = D[CNT_W:0];

  logic [CNT_W-1:0] count;
  logic             deq;
  logic             enq;
  logic [CNT_W:0]   credit_used;
  logic             inflight_q, inflight_d;
  logic             err_q, err_d;

  assign out_vld = (count != '0) && !flush;
  assign deq     = out_vld && out_rdy;

  // A slot freed by this cycle's dequeue is credited immediately, sustaining full rate at D=2.
  assign credit_used = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(deq);
  assign fifo_pop    = !rst && !fifo_empty_r && !flush && (credit_used < DEPTH);

  // Unsolicited data (error case) is only stored if there is room.
  assign enq = fifo_pop_data_vld_r && !flush && ({1'b0, count} != DEPTH);

  assign inflight_d = fifo_pop;
  assign err_d      = err_q || (fifo_pop_data_vld_r && !inflight_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  fifo_async_pop_buf #(.W(W), .D(D)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (flush),
    .enq_i      (enq),
    .enq_data_i (fifo_pop_data),
    .deq_i      (deq),
    .head_o     (out_data),
    .count_o    (count)
  );

  assign level_r = count;
  assign err_r   = err_q;
endmodule

// File: tb/tb_fifo_async_pop_ctrl.sv
// Bench for fifo_async_pop_ctrl: a source FIFO model drives the DUT and a queue-level
// reference model predicts every output each cycle; directed phases add literal checks.
module tb_fifo_async_pop_ctrl;
  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty_r = 1'b1;
  logic         fifo_pop;
  logic [W-1:0] fifo_pop_data = '0;
  logic         fifo_pop_data_vld_r = 1'b0;
  logic         flush = 1'b0;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic         out_rdy = 1'b0;
  logic [1:0]   level_r;
  logic         err_r;

  always #5 clk = ~clk;

  fifo_async_pop_ctrl #(.W(W), .D(D)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_empty_r        (fifo_empty_r),
    .fifo_pop            (fifo_pop),
    .fifo_pop_data       (fifo_pop_data),
    .fifo_pop_data_vld_r (fifo_pop_data_vld_r),
    .flush               (flush),
    .out_vld             (out_vld),
    .out_data            (out_data),
    .out_rdy             (out_rdy),
    .level_r             (level_r),
    .err_r               (err_r)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0] src[$];
  logic         inj = 1'b0;
  logic [W-1:0] mq[$];
  bit           m_inf = 1'b0;
  bit           m_err = 1'b0;

  int           pop_cyc[$];
  logic [W-1:0] got[$];
  int           got_cyc[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic load(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) src.push_back(base + W'(i));
    if (n > 0) fifo_empty_r = 1'b0;
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    got.delete();
    got_cyc.delete();
  endtask

  // One clock cycle: check at negedge, advance model and source FIFO just after posedge.
  task automatic step();
    bit           mv, md, mp, room;
    bit           dpop, vld_s, fl_s, rst_s;
    logic [W-1:0] dat_s;
    @(negedge clk);
    mv = !rst && (mq.size() != 0) && !flush;
    md = mv && out_rdy;
    mp = !rst && !fifo_empty_r && !flush && ((mq.size() + int'(m_inf) - int'(md)) < D);
    chk("out_vld", W'(out_vld), W'(mv));
    if (mv) chk("out_data", out_data, mq[0]);
    chk("fifo_pop", W'(fifo_pop), W'(mp));
    chk("level_r", W'(level_r), rst ? W'(0) : W'(mq.size()));
    chk("err_r", W'(err_r), rst ? W'(0) : W'(m_err));
    if (fifo_pop) pop_cyc.push_back(cyc);
    if (out_vld && out_rdy) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    dpop  = fifo_pop;
    vld_s = fifo_pop_data_vld_r;
    dat_s = fifo_pop_data;
    fl_s  = flush;
    rst_s = rst;
    @(posedge clk);
    #1;
    if (rst_s) begin
      mq.delete();
      m_inf = 1'b0;
      m_err = 1'b0;
    end else begin
      if (vld_s && !m_inf) m_err = 1'b1;
      if (fl_s) begin
        mq.delete();
        m_inf = 1'b0;
      end else begin
        room = mq.size() < D;
        if (md) void'(mq.pop_front());
        if (vld_s && room) mq.push_back(dat_s);
        m_inf = mp;
      end
    end
    if (rst_s) begin
      fifo_pop_data_vld_r = 1'b0;
    end else if (dpop && src.size() != 0) begin
      fifo_pop_data       = src.pop_front();
      fifo_pop_data_vld_r = 1'b1;
    end else if (inj) begin
      fifo_pop_data       = 32'hDEAD_BEEF;
      fifo_pop_data_vld_r = 1'b1;
      inj                 = 1'b0;
    end else begin
      fifo_pop_data_vld_r = 1'b0;
    end
    fifo_empty_r = (src.size() == 0);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [W-1:0] nxt;

  initial begin
    // Reset held with a non-empty FIFO
    load(8, 32'h10);
    run(3);
    chk("rst_pop", W'(fifo_pop), W'(0));
    chk("rst_vld", W'(out_vld), W'(0));
    chk("rst_level", W'(level_r), W'(0));
    chk("rst_err", W'(err_r), W'(0));
    rst = 1'b0;
    out_rdy = 1'b1;
    #1;
    chk("pop_after_rst", W'(fifo_pop), W'(1));

    // Streaming 0x10..0x17
    clear_logs();
    run(14);
    chk("stream_pops", W'(pop_cyc.size()), W'(8));
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("stream_pop_consec", W'(pop_cyc[i]), W'(pop_cyc[0] + i));
    chk("stream_words", W'(got.size()), W'(8));
    for (int i = 0; i < got.size(); i++) begin
      chk("stream_data", got[i], 32'h10 + W'(i));
      chk("stream_cycle", W'(got_cyc[i]), W'(pop_cyc[0] + 2 + i));
    end

    // Backpressure with 5 words
    out_rdy = 1'b0;
    clear_logs();
    load(5, 32'h20);
    run(6);
    chk("bp_pops", W'(pop_cyc.size()), W'(2));
    chk("bp_level", W'(level_r), W'(2));
    chk("bp_pop_stall", W'(fifo_pop), W'(0));
    out_rdy = 1'b1;
    clear_logs();
    run(10);
    chk("bp_words", W'(got.size()), W'(5));
    for (int i = 0; i < got.size(); i++) chk("bp_data", got[i], 32'h20 + W'(i));

    // Empty boundary: a single word
    clear_logs();
    load(1, 32'h30);
    run(6);
    chk("one_pops", W'(pop_cyc.size()), W'(1));
    chk("one_words", W'(got.size()), W'(1));
    if (got.size() > 0) chk("one_data", got[0], 32'h30);
    chk("one_level", W'(level_r), W'(0));

    // Flush in steady streaming (word buffered plus one in flight)
    load(16, 32'h40);
    run(5);
    chk("fl_pre_level", W'(level_r), W'(1));
    nxt = src[0];
    flush = 1'b1;
    #1;
    chk("fl_vld", W'(out_vld), W'(0));
    chk("fl_pop", W'(fifo_pop), W'(0));
    clear_logs();
    step();
    flush = 1'b0;
    chk("fl_level", W'(level_r), W'(0));
    run(14);
    chk("fl_words", W'(got.size() > 0), W'(1));
    for (int i = 0; i < got.size(); i++) chk("fl_data", got[i], nxt + W'(i));

    // Error: unsolicited data
    run(6);
    inj = 1'b1;
    run(2);
    chk("err_set", W'(err_r), W'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("err_flush", W'(err_r), W'(1));
    rst = 1'b1;
    fifo_pop_data_vld_r = 1'b0;
    #1;
    chk("err_rst", W'(err_r), W'(0));
    step();
    rst = 1'b0;

    // Reset mid-stream: no spurious error afterwards
    load(6, 32'h60);
    run(3);
    rst = 1'b1;
    fifo_pop_data_vld_r = 1'b0;
    step();
    rst = 1'b0;
    run(10);
    chk("midrst_err", W'(err_r), W'(0));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) load($urandom_range(1, 6), $urandom());
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        fifo_pop_data_vld_r = 1'b0;
      end else begin
        rst = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
